// File: rtl/corner_nms.sv
// Harris-score non-maximum suppression over a 3x3 window on a raster stream.
// Reports thresholded local maxima with their coordinates and counts corners per frame.
module corner_nms #(
  parameter int SCORE_W = 32,
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [SCORE_W-1:0] score,
  input  logic                      score_valid,
  input  logic signed [SCORE_W-1:0] threshold,
  output logic                      corner_valid,
  output logic [15:0]               corner_x,
  output logic [15:0]               corner_y,
  output logic signed [SCORE_W-1:0] corner_score,
  output logic                      frame_done,
  output logic [15:0]               corner_count
);

  localparam int          XW     = $clog2(IMG_W);
  localparam logic [15:0] X_LAST = 16'(IMG_W - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_H - 1);

  logic [15:0] x_r, y_r, cnt_r;
  logic signed [SCORE_W-1:0] thr_r;
  logic signed [SCORE_W-1:0] lb0_r [IMG_W];
  logic signed [SCORE_W-1:0] lb1_r [IMG_W];
  // Column a is x-2, column b is x-1; the incoming column (x) comes straight from the line buffers.
  logic signed [SCORE_W-1:0] a_top_r, a_mid_r, a_bot_r;
  logic signed [SCORE_W-1:0] b_top_r, b_mid_r, b_bot_r;

  logic [XW-1:0]             x_idx_s;
  logic signed [SCORE_W-1:0] n_top_s, n_mid_s;
  logic                      is_corner_s;
  logic                      last_s;
  logic [15:0]               cnt_next_s;

  // Window neighbourhood compare and per-frame count update.
  always_comb begin
    x_idx_s     = x_r[XW-1:0];
    n_top_s     = lb1_r[x_idx_s];
    n_mid_s     = lb0_r[x_idx_s];
    last_s      = (x_r == X_LAST) && (y_r == Y_LAST);
    // The x>=2 / y>=2 gate keeps the window inside this frame and off the image border.
    is_corner_s = score_valid && (x_r >= 16'd2) && (y_r >= 16'd2) &&
                  (b_mid_r > thr_r) &&
                  (b_mid_r > a_top_r) && (b_mid_r > b_top_r) && (b_mid_r > n_top_s) &&
                  (b_mid_r > a_mid_r) && (b_mid_r >= n_mid_s) &&
                  (b_mid_r >= a_bot_r) && (b_mid_r >= b_bot_r) && (b_mid_r >= score);
    if (is_corner_s && (cnt_r != 16'hFFFF)) begin
      cnt_next_s = cnt_r + 16'd1;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Line buffers: lb0 holds row y-1, lb1 holds row y-2; no reset needed.
  always_ff @(posedge clk) begin
    if (score_valid && !reset) begin
      lb1_r[x_idx_s] <= n_mid_s;
      lb0_r[x_idx_s] <= score;
    end
  end

  // Raster counters, window shift, threshold capture and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r          <= 16'd0;
      y_r          <= 16'd0;
      cnt_r        <= 16'd0;
      thr_r        <= '0;
      a_top_r      <= '0;
      a_mid_r      <= '0;
      a_bot_r      <= '0;
      b_top_r      <= '0;
      b_mid_r      <= '0;
      b_bot_r      <= '0;
      corner_valid <= 1'b0;
      frame_done   <= 1'b0;
      corner_x     <= 16'd0;
      corner_y     <= 16'd0;
      corner_score <= '0;
      corner_count <= 16'd0;
    end else begin
      corner_valid <= 1'b0;
      frame_done   <= 1'b0;
      if (score_valid) begin
        if (x_r == X_LAST) begin
          x_r <= 16'd0;
          y_r <= (y_r == Y_LAST) ? 16'd0 : y_r + 16'd1;
        end else begin
          x_r <= x_r + 16'd1;
        end
        if ((x_r == 16'd0) && (y_r == 16'd0)) begin
          thr_r <= threshold;
        end
        a_top_r <= b_top_r;
        a_mid_r <= b_mid_r;
        a_bot_r <= b_bot_r;
        b_top_r <= n_top_s;
        b_mid_r <= n_mid_s;
        b_bot_r <= score;
        if (is_corner_s) begin
          corner_valid <= 1'b1;
          corner_x     <= x_r - 16'd1;
          corner_y     <= y_r - 16'd1;
          corner_score <= b_mid_r;
        end
        if (last_s) begin
          frame_done   <= 1'b1;
          corner_count <= cnt_next_s;
          cnt_r        <= 16'd0;
        end else begin
          cnt_r <= cnt_next_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_corner_nms.sv
// Scoreboard bench for corner_nms on an 8x6 image: the driver queues expected
// corner and frame_done events, an independent monitor pops and compares them.
module tb_corner_nms;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int SW = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic signed [SW-1:0] score = '0;
  logic                 score_valid = 1'b0;
  logic signed [SW-1:0] threshold = '0;
  logic                 corner_valid;
  logic [15:0]          corner_x;
  logic [15:0]          corner_y;
  logic signed [SW-1:0] corner_score;
  logic                 frame_done;
  logic [15:0]          corner_count;

  corner_nms #(.SCORE_W(SW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .score(score), .score_valid(score_valid),
    .threshold(threshold), .corner_valid(corner_valid), .corner_x(corner_x),
    .corner_y(corner_y), .corner_score(corner_score), .frame_done(frame_done),
    .corner_count(corner_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int a;
    int b;
    int c;
  } ev_t;

  ev_t cq[$];
  ev_t fq[$];
  int  cyc = 0;
  int  n_run = 0;
  int  n_fail = 0;
  int  last_x = 0, last_y = 0, last_s = 0;
  int  img [W*H];
  int  ex_x [4], ex_y [4], ex_s [4];
  int  n_ex = 0;
  bit  gaps = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always begin
    ev_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (cq.size() > 0 && cq[0].cyc < cyc) begin
      e = cq.pop_front();
      chk("corner_missing", 0, 1);
    end
    if (fq.size() > 0 && fq[0].cyc < cyc) begin
      e = fq.pop_front();
      chk("frame_done_missing", 0, 1);
    end
    if (corner_valid === 1'b1) begin
      if (cq.size() == 0) begin
        chk("corner_unexpected", 1, 0);
      end else begin
        e = cq.pop_front();
        chk("corner_cycle", cyc, e.cyc);
        chk("corner_x", int'(corner_x), e.a);
        chk("corner_y", int'(corner_y), e.b);
        chk("corner_score", int'(corner_score), e.c);
        last_x = e.a;
        last_y = e.b;
        last_s = e.c;
      end
    end
    if (frame_done === 1'b1) begin
      if (fq.size() == 0) begin
        chk("frame_done_unexpected", 1, 0);
      end else begin
        e = fq.pop_front();
        chk("frame_done_cycle", cyc, e.cyc);
        chk("corner_count", int'(corner_count), e.a);
        if (corner_valid !== 1'b1) begin
          chk("hold_x", int'(corner_x), last_x);
          chk("hold_y", int'(corner_y), last_y);
          chk("hold_score", int'(corner_score), last_s);
        end
      end
    end
  end

  task automatic set_img(input int bg);
    for (int i = 0; i < W*H; i++) img[i] = bg;
    n_ex = 0;
  endtask

  task automatic pix(input int px, input int py, input int v);
    img[py*W + px] = v;
  endtask

  task automatic exp_c(input int px, input int py, input int s);
    ex_x[n_ex] = px;
    ex_y[n_ex] = py;
    ex_s[n_ex] = s;
    n_ex++;
  endtask

  // A valid score is presented during reset and must be discarded.
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    score_valid = 1'b1;
    score = 32'sd999;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    score_valid = 1'b0;
    last_x = 0;
    last_y = 0;
    last_s = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_corner_valid"}, int'(corner_valid), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_corner_x"}, int'(corner_x), 0);
    chk({tag, "_corner_y"}, int'(corner_y), 0);
    chk({tag, "_corner_score"}, int'(corner_score), 0);
    chk({tag, "_corner_count"}, int'(corner_count), 0);
  endtask

  task automatic send_frame(input int count);
    ev_t e;
    int  px, py;
    for (int i = 0; i < count; i++) begin
      px = i % W;
      py = i / W;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          score_valid = 1'b0;
          score = 32'sd12345;
        end
      end
      @(negedge clk);
      score_valid = 1'b1;
      score = img[i];
      for (int k = 0; k < n_ex; k++) begin
        if (px == ex_x[k] + 1 && py == ex_y[k] + 1) begin
          e.cyc = cyc + 1; e.a = ex_x[k]; e.b = ex_y[k]; e.c = ex_s[k];
          cq.push_back(e);
        end
      end
      if (i == W*H - 1) begin
        e.cyc = cyc + 1; e.a = n_ex; e.b = 0; e.c = 0;
        fq.push_back(e);
      end
    end
    @(negedge clk);
    score_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic img_single_peak();
    set_img(0);
    pix(3, 2, 100);
    exp_c(3, 2, 100);
  endtask

  initial begin
    threshold = 32'sd10;
    do_reset(3);
    chk_zero("reset");

    img_single_peak();
    send_frame(W*H);

    set_img(0);
    pix(3, 2, 50);
    pix(4, 2, 50);
    exp_c(3, 2, 50);
    send_frame(W*H);

    set_img(0);
    pix(0, 0, 100);
    pix(7, 5, 100);
    pix(7, 2, 100);
    pix(3, 0, 100);
    pix(4, 3, 10);
    send_frame(W*H);

    threshold = -32'sd5;
    set_img(-10);
    pix(6, 4, -1);
    exp_c(6, 4, -1);
    send_frame(W*H);

    threshold = 32'sd10;
    img_single_peak();
    send_frame(20);
    do_reset(2);
    chk_zero("midreset");
    gaps = 1'b1;
    send_frame(W*H);

    repeat (5) @(negedge clk);
    chk("corner_queue_empty", cq.size(), 0);
    chk("frame_queue_empty", fq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/corner_nms.md
CORNER_NMS -- requirements
Module: corner_nms

Interface
REQ-001 SHALL have parameter SCORE_W, default 32, width of signed Harris score.
REQ-002 SHALL have parameter IMG_W, default 64, pixels per row, legal range 3..65535.
REQ-003 SHALL have parameter IMG_H, default 64, rows per frame, legal range 3..65535.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port score  input  SCORE_W  signed Harris response, raster order.
REQ-007 SHALL have port score_valid  input  1  score is valid this cycle, no backpressure.
REQ-008 SHALL have port threshold  input  SCORE_W  signed corner threshold.
REQ-009 SHALL have port corner_valid  output  1  one-cycle pulse, a corner is reported.
REQ-010 SHALL have port corner_x  output  16  column of reported corner.
REQ-011 SHALL have port corner_y  output  16  row of reported corner.
REQ-012 SHALL have port corner_score  output  SCORE_W  score of reported corner.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after last score of a frame.
REQ-014 SHALL have port corner_count  output  16  corners in last completed frame.

Function
REQ-015 SHALL keep column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1), both advanced only on cycles with score_valid=1.
REQ-016 SHALL wrap x to 0 and increment y after x=IMG_W-1, and wrap y to 0 after (IMG_W-1, IMG_H-1).
REQ-017 SHALL ignore cycles with score_valid=0: no counter, buffer, window or output state change except one-cycle pulses returning to 0.
REQ-018 SHALL store the two previous rows in two IMG_W-deep line buffers and form a 3x3 window centred on (x-1, y-1) when score at (x, y) is accepted.
REQ-019 SHALL sample threshold when the score at (0,0) is accepted and use that value for the whole frame.
REQ-020 SHALL declare centre C a corner iff C > threshold, C > each of its up-left, up, up-right and left neighbours, and C >= each of its right, down-left, down and down-right neighbours, all compares signed.
REQ-021 SHALL never report a centre in row 0, row IMG_H-1, column 0 or column IMG_W-1.
REQ-022 SHALL assert corner_valid for exactly one cycle, the cycle after the score at (cx+1, cy+1) is accepted, with corner_x=cx, corner_y=cy, corner_score=C.
REQ-023 SHALL hold corner_x, corner_y, corner_score at their last values while corner_valid=0.
REQ-024 SHALL pulse frame_done for one cycle, the cycle after the score at (IMG_W-1, IMG_H-1) is accepted, coincident with any corner_valid for centre (IMG_W-2, IMG_H-2).
REQ-025 SHALL count corners per frame in an internal 16-bit counter saturating at 65535, including a corner reported in the frame_done cycle.
REQ-026 SHALL load corner_count from the internal counter in the frame_done cycle and clear the internal counter for the next frame.
REQ-027 SHALL produce no output that depends on line-buffer contents written before the current frame's row 0.

Reset
REQ-028 SHALL on reset=1 at a clock edge clear x, y, window registers, internal count, corner_valid, frame_done, corner_x, corner_y, corner_score and corner_count to 0.
REQ-029 SHALL not require line-buffer contents to be reset.
REQ-030 SHALL treat the first accepted score after reset as pixel (0,0) of a new frame, including when reset is asserted mid-frame.
REQ-031 SHALL give reset priority over score_valid in the same cycle, discarding that score.

Verification (IMG_W=8, IMG_H=6)
REQ-032 SHALL verify: reset held 3 cycles -> all outputs 0; no corner_valid or frame_done until 48 scores are accepted.
REQ-033 SHALL verify: all scores 0, threshold 10, score 100 at (3,2) -> exactly one corner_valid (x=3, y=2, score=100), one cycle after (4,3) is accepted; corner_count=1 at frame_done.
REQ-034 SHALL verify: threshold 10, score 50 at (3,2) and (4,2), all other scores 0 -> only (3,2) reported; corner_count=1.
REQ-035 SHALL verify: threshold 10, score 100 at (0,0), (7,5), (7,2) and (3,0); score 10 at (4,3); all other scores 0 -> no corners, corner_count=0.
REQ-036 SHALL verify: threshold -5, all scores -10 except -1 at (6,4) -> corner (6,4) reported in the frame_done cycle; corner_count=1.
REQ-037 SHALL verify: REQ-033 stimulus with random score_valid gaps, preceded by reset after 20 scores -> outputs and coordinates identical to the gap-free run.
